rice_encoder: RTL and testbench

//  Upstream stage of the Rice bit-packer: turns a stream of signed 16-bit LPC residuals into

---
 rtl/rice_pkg.sv | 28 ++
 rtl/rice_zigzag.sv | 13 +
 rtl/rice_encoder.sv | 161 ++++++++++++++++
 tb/tb_rice_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_pkg.sv
// Shared definitions for the Rice encoder, the Rice bit-packer and their benches.
package rice_pkg;

  localparam int RES_W     = 16;
  localparam int PARAM_W   = 4;
  localparam int MAX_PARAM = 14;

  // Stage-2 phase of the entry currently held in stage 1
  typedef enum logic [1:0] {
    ST_CODE,
    ST_PARAM,
    ST_FLUSH
  } stage_e;

  // Command kind as seen by the packer
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CODE,
    CMD_PARAM,
    CMD_FLUSH
  } cmd_e;

  // Limit a requested Rice parameter to the largest one the packer supports
  function automatic logic [PARAM_W-1:0] clampParam(input logic [PARAM_W-1:0] k);
    return (k > PARAM_W'(MAX_PARAM)) ? PARAM_W'(MAX_PARAM) : k;
  endfunction

endpackage

// File: rtl/rice_zigzag.sv
// Signed-to-unsigned zigzag map: r >= 0 -> 2r, r < 0 -> -2r-1.
// Shared with the parameter estimator, so it stays purely combinational.
module rice_zigzag
  import rice_pkg::*;
(
  input  logic [RES_W-1:0] residual_i,
  output logic [RES_W-1:0] mapped_o
);

  // Shifting left and inverting for negative inputs gives -2r-1 without an adder
  assign mapped_o = {residual_i[RES_W-2:0], 1'b0} ^ {RES_W{residual_i[RES_W-1]}};

endmodule

// File: rtl/rice_encoder.sv
// Rice encoder front end: residual -> zigzag -> code-word / change-param / flush commands.
// Stage 1 holds one accepted sample; the stage-2 FSM walks it through PARAM, CODE and
// FLUSH and registers one command per cycle for the packer.
module rice_encoder
  import rice_pkg::*;
(
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iValid,
  output logic               oReady,
  input  logic [RES_W-1:0]   iResidual,
  input  logic               iPartStart,
  input  logic               iLast,
  input  logic [PARAM_W-1:0] iRiceParam,
  output logic               oValid,
  output logic               oChangeParam,
  output logic               oFlush,
  output logic [RES_W-1:0]   oTotal,
  output logic [RES_W-1:0]   oUpper,
  output logic [RES_W-1:0]   oLower,
  output logic [PARAM_W-1:0] oRiceParam,
  output logic               oOverflow
);

  logic [RES_W-1:0]   mappedIn;

  logic               readyEn_q;
  logic               s1Valid_q, s1Valid_d;
  logic [RES_W-1:0]   mapped_q;
  logic               last_q;
  logic [PARAM_W-1:0] k_q;
  stage_e             state_q, state_d;

  cmd_e               cmd_q, cmd_d;
  logic [RES_W-1:0]   total_q, total_d;
  logic [RES_W-1:0]   upper_q, upper_d;
  logic [RES_W-1:0]   lower_q, lower_d;
  logic [PARAM_W-1:0] outK_q, outK_d;
  logic               overflow_q, overflow_d;

  logic               retire;
  logic               transfer;
  logic [RES_W-1:0]   maskW;
  logic [RES_W-1:0]   upperW;
  logic [RES_W-1:0]   lowerW;
  logic [RES_W:0]     totalW;

  rice_zigzag u_zigzag (
    .residual_i (iResidual),
    .mapped_o   (mappedIn)
  );

  // Code-word fields for the held sample; total keeps a 17th bit to spot overflow
  always_comb begin
    maskW  = (RES_W'(1) << k_q) - RES_W'(1);
    upperW = mapped_q >> k_q;
    lowerW = (RES_W'(1) << k_q) | (mapped_q & maskW);
    totalW = {1'b0, upperW} + (RES_W+1)'(k_q) + (RES_W+1)'(1);
  end

  // Stage-2 FSM: pick this cycle's command, decide whether stage 1 frees up, accept input
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    cmd_d      = CMD_NONE;
    total_d    = '0;
    upper_d    = '0;
    lower_d    = '0;
    outK_d     = '0;
    overflow_d = overflow_q;
    if (s1Valid_q) begin
      outK_d = k_q;
      case (state_q)
        ST_PARAM: begin
          cmd_d   = CMD_PARAM;
          state_d = ST_CODE;
        end
        ST_CODE: begin
          cmd_d   = CMD_CODE;
          upper_d = upperW;
          lower_d = lowerW;
          if (totalW[RES_W]) begin
            total_d    = '1;
            overflow_d = 1'b1;
          end else begin
            total_d = totalW[RES_W-1:0];
          end
          if (last_q) begin
            state_d = ST_FLUSH;
          end else begin
            retire = 1'b1;
          end
        end
        ST_FLUSH: begin
          cmd_d   = CMD_FLUSH;
          state_d = ST_CODE;
          retire  = 1'b1;
        end
        default: state_d = ST_CODE;
      endcase
    end
    oReady    = readyEn_q && (!s1Valid_q || retire);
    transfer  = iValid && oReady;
    s1Valid_d = transfer || (s1Valid_q && !retire);
    if (transfer) begin
      state_d = iPartStart ? ST_PARAM : ST_CODE;
    end
  end

  // Stage 1 accept register plus FSM state; k only moves at a partition start
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      readyEn_q <= 1'b0;
      s1Valid_q <= 1'b0;
      mapped_q  <= '0;
      last_q    <= 1'b0;
      k_q       <= '0;
      state_q   <= ST_CODE;
    end else begin
      readyEn_q <= 1'b1;
      s1Valid_q <= s1Valid_d;
      state_q   <= state_d;
      if (transfer) begin
        mapped_q <= mappedIn;
        last_q   <= iLast;
        if (iPartStart) begin
          k_q <= clampParam(iRiceParam);
        end
      end
    end
  end

  // Registered command outputs so the packer sees clean single-cycle pulses
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      cmd_q      <= CMD_NONE;
      total_q    <= '0;
      upper_q    <= '0;
      lower_q    <= '0;
      outK_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      total_q    <= total_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      outK_q     <= outK_d;
      overflow_q <= overflow_d;
    end
  end

  assign oValid       = (cmd_q != CMD_NONE);
  assign oChangeParam = (cmd_q == CMD_PARAM);
  assign oFlush       = (cmd_q == CMD_FLUSH);
  assign oTotal       = total_q;
  assign oUpper       = upper_q;
  assign oLower       = lower_q;
  assign oRiceParam   = outK_q;
  assign oOverflow    = overflow_q;

endmodule

// File: tb/tb_rice_encoder.sv
// Self-checking bench for rice_encoder: directed steps feed a scoreboard of expected
// commands, and a monitor compares every emitted command against it.
module tb_rice_encoder;
  import rice_pkg::*;

  typedef struct {
    cmd_e        kind;
    logic [3:0]  k;
    logic [15:0] upper;
    logic [15:0] lower;
    logic [15:0] total;
  } exp_t;

  logic        iClock;
  logic        iReset;
  logic        iValid;
  logic        oReady;
  logic [15:0] iResidual;
  logic        iPartStart;
  logic        iLast;
  logic [3:0]  iRiceParam;
  logic        oValid;
  logic        oChangeParam;
  logic        oFlush;
  logic [15:0] oTotal;
  logic [15:0] oUpper;
  logic [15:0] oLower;
  logic [3:0]  oRiceParam;
  logic        oOverflow;

  exp_t       expQ[$];
  int         testsRun  = 0;
  int         failCount = 0;
  int         paramSeen = 0;
  logic [3:0] modelK    = 4'd0;

  rice_encoder dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iValid       (iValid),
    .oReady       (oReady),
    .iResidual    (iResidual),
    .iPartStart   (iPartStart),
    .iLast        (iLast),
    .iRiceParam   (iRiceParam),
    .oValid       (oValid),
    .oChangeParam (oChangeParam),
    .oFlush       (oFlush),
    .oTotal       (oTotal),
    .oUpper       (oUpper),
    .oLower       (oLower),
    .oRiceParam   (oRiceParam),
    .oOverflow    (oOverflow)
  );

  // Free-running 10-unit clock
  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // One comparison: count it, and report tag/observed/expected when it does not hold
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference zigzag mapping written with plain integer arithmetic
  function automatic logic [15:0] zigzagModel(input int r);
    return (r >= 0) ? 16'(2 * r) : 16'(-2 * r - 1);
  endfunction

  // Queue the command(s) one accepted sample is expected to produce
  function automatic void pushExpected(input int r, input bit ps, input bit last,
                                       input logic [3:0] param);
    exp_t e;
    int   mapped, div, up, lo, tot;
    if (ps) begin
      modelK  = (param > 4'd14) ? 4'd14 : param;
      e.kind  = CMD_PARAM; e.k = modelK; e.upper = '0; e.lower = '0; e.total = '0;
      expQ.push_back(e);
    end
    mapped = int'(zigzagModel(r));
    div    = 1 << modelK;
    up     = mapped / div;
    lo     = div + (mapped % div);
    tot    = up + int'(modelK) + 1;
    if (tot > 65535) tot = 65535;
    e.kind  = CMD_CODE; e.k = modelK;
    e.upper = 16'(up); e.lower = 16'(lo); e.total = 16'(tot);
    expQ.push_back(e);
    if (last) begin
      e.kind = CMD_FLUSH; e.k = modelK; e.upper = '0; e.lower = '0; e.total = '0;
      expQ.push_back(e);
    end
  endfunction

  // Offer one sample, wait (bounded) for oReady, transfer it and record expectations
  task automatic applyStimulus(input int r, input bit ps, input bit last,
                               input logic [3:0] param);
    int waitCycles = 0;
    @(negedge iClock);
    iValid     = 1'b1;
    iResidual  = 16'(r);
    iPartStart = ps;
    iLast      = last;
    iRiceParam = param;
    while (!oReady && waitCycles < 50) begin
      @(negedge iClock);
      waitCycles++;
    end
    if (oReady !== 1'b1) begin
      checkOutput("readyTimeout", 32'(oReady), 32'd1);
      iValid = 1'b0;
      return;
    end
    @(posedge iClock);
    pushExpected(r, ps, last, param);
    #1;
    iValid     = 1'b0;
    iPartStart = 1'b0;
    iLast      = 1'b0;
  endtask

  // Wait (bounded) until every expected command has been seen
  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge iClock);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: compare each emitted command with the head of the scoreboard
  always @(negedge iClock) begin
    exp_t e;
    if (!iReset && oValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedCmd", 32'(oValid), 32'd0);
      end else begin
        e = expQ.pop_front();
        if (oChangeParam === 1'b1) paramSeen++;
        checkOutput("changeParam", 32'(oChangeParam), 32'(e.kind == CMD_PARAM));
        checkOutput("flush", 32'(oFlush), 32'(e.kind == CMD_FLUSH));
        checkOutput("riceParam", 32'(oRiceParam), 32'(e.k));
        checkOutput("upper", 32'(oUpper), 32'(e.upper));
        checkOutput("lower", 32'(oLower), 32'(e.lower));
        checkOutput("total", 32'(oTotal), 32'(e.total));
      end
    end
  end

  // Hard stop in case something upstream of the bounded waits wedges
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin
    logic [3:0] params [4];
    int         base;
    int         r;
    params[0] = 4'd1; params[1] = 4'd3; params[2] = 4'd7; params[3] = 4'd15;

    iReset = 1'b1; iValid = 1'b0; iResidual = '0;
    iPartStart = 1'b0; iLast = 1'b0; iRiceParam = '0;

    // Reset state
    repeat (2) @(negedge iClock);
    checkOutput("rstValid", 32'(oValid), 32'd0);
    checkOutput("rstReady", 32'(oReady), 32'd0);
    checkOutput("rstOverflow", 32'(oOverflow), 32'd0);
    checkOutput("rstTotal", 32'(oTotal), 32'd0);
    iReset = 1'b0;
    @(negedge iClock);
    checkOutput("readyAfterRst", 32'(oReady), 32'd1);

    // Small residuals, k=2
    applyStimulus(0, 1'b1, 1'b0, 4'd2);
    applyStimulus(-1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1, 1'b0, 1'b0, 4'd0);
    applyStimulus(-2, 1'b0, 1'b0, 4'd0);
    waitDrain();

    // k=0 and clamp of 15 to 14
    applyStimulus(5, 1'b1, 1'b0, 4'd0);
    applyStimulus(1000, 1'b1, 1'b0, 4'd15);
    waitDrain();
    checkOutput("noOverflowYet", 32'(oOverflow), 32'd0);

    // Saturation and sticky overflow
    applyStimulus(-32768, 1'b1, 1'b0, 4'd0);
    applyStimulus(3, 1'b0, 1'b0, 4'd0);
    waitDrain();
    checkOutput("overflowSet", 32'(oOverflow), 32'd1);
    repeat (3) @(negedge iClock);
    checkOutput("overflowSticky", 32'(oOverflow), 32'd1);
    iReset = 1'b1;
    #1;
    checkOutput("overflowCleared", 32'(oOverflow), 32'd0);
    @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock);

    // Part start and last on one sample: PARAM, CODE, FLUSH back to back
    applyStimulus(7, 1'b1, 1'b1, 4'd3);
    @(negedge iClock);
    checkOutput("stallReadyA", 32'(oReady), 32'd0);
    @(negedge iClock);
    checkOutput("stallReadyB", 32'(oReady), 32'd0);
    checkOutput("seqParam", 32'({oValid, oChangeParam, oFlush}), 32'b110);
    @(negedge iClock);
    checkOutput("readyAfterStall", 32'(oReady), 32'd1);
    checkOutput("seqCode", 32'({oValid, oChangeParam, oFlush}), 32'b100);
    @(negedge iClock);
    checkOutput("seqFlush", 32'({oValid, oChangeParam, oFlush}), 32'b101);
    applyStimulus(-3, 1'b0, 1'b0, 4'd0);
    waitDrain();

    // 64-sample stream, new partition every 16 samples
    base = paramSeen;
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom_range(65535)) - 32768;
      applyStimulus(r, (i % 16) == 0, i == 63, params[i / 16]);
    end
    waitDrain();
    checkOutput("paramCount", 32'(paramSeen - base), 32'd4);

    // Reset while a partition-start sample is stalled behind its PARAM command
    applyStimulus(9, 1'b1, 1'b0, 4'd5);
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    expQ.delete();
    #1;
    checkOutput("midRstValid", 32'(oValid), 32'd0);
    checkOutput("midRstParam", 32'(oChangeParam), 32'd0);
    checkOutput("midRstReady", 32'(oReady), 32'd0);
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge iClock);
      checkOutput("quietAfterRst", 32'(oValid), 32'd0);
    end

    // Encoder still works after the mid-stream reset
    applyStimulus(2, 1'b1, 1'b0, 4'd1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
